dev_bridge: RTL and testbench

- System bridge between the CPU data-memory port and memory-mapped peripherals: two timer devices plus a built-in interrupt controller.
- Decodes CPU accesses, steers write enables, and returns registered read data with a one-cycle valid strobe.
- Latches rising edges of device IRQ lines into a pending register, masks them, and drives the 6-bit HWInt vector to CP0.

---
 rtl/dev_bridge_pkg.sv | 43 ++++
 rtl/dev_bridge_if.sv | 24 ++
 rtl/dev_bridge_irq_ctrl.sv | 81 ++++++++
 rtl/dev_bridge.sv | 105 ++++++++++
 tb/tb_dev_bridge.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: address map,
// interrupt-controller register indices, IRQ numbering and decode select type.
package dev_bridge_pkg;

    localparam int N_IRQ = 6;

    localparam logic [31:0] T0_BASE   = 32'h0000_7F00;
    localparam logic [31:0] T1_BASE   = 32'h0000_7F10;
    localparam logic [31:0] IC_BASE   = 32'h0000_7F20;

    // Window sizes in bytes: timers expose ctrl/preset/count, the IC four registers.
    localparam logic [31:0] TIMER_WIN = 32'd12;
    localparam logic [31:0] IC_WIN    = 32'd16;

    // Interrupt-controller registers, indexed by word (cpu_addr[3:2]).
    localparam logic [1:0] IC_IMR  = 2'd0;
    localparam logic [1:0] IC_IPR  = 2'd1;
    localparam logic [1:0] IC_IVEC = 2'd2;
    localparam logic [1:0] IC_ICNT = 2'd3;

    localparam int IRQ_T0 = 0;
    localparam int IRQ_T1 = 1;

    typedef enum logic [1:0] {
        SEL_T0   = 2'd0,
        SEL_T1   = 2'd1,
        SEL_IC   = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    // Index of the lowest set bit, or all ones when no bit is set.
    function automatic logic [31:0] lowest_set_index(input logic [N_IRQ-1:0] v);
        logic [31:0] idx;
        idx = 32'hFFFF_FFFF;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dev_bridge_if.sv
// CPU data-memory port as seen by the bridge: request side from the CPU,
// registered read data and error strobe back to it.
interface dev_bridge_if;
    import dev_bridge_pkg::*;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, rvalid, err
    );

endinterface

// File: rtl/dev_bridge_irq_ctrl.sv
// Interrupt controller: captures rising edges of the IRQ lines into a
// pending register, masks them, and presents a registered vector to CP0.
// Registers: IMR (rw), IPR (write-1-to-clear), IVEC (ro), ICNT (ro).
module irq_ctrl
    import dev_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       reg_idx,
    input  logic [N_IRQ-1:0] wdata,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [31:0]      rdata,
    output logic [N_IRQ-1:0] hw_int
);

    logic [N_IRQ-1:0] imr_q, imr_d;
    logic [N_IRQ-1:0] ipr_q, ipr_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] hw_int_q, hw_int_d;
    logic [31:0]      icnt_q, icnt_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] masked;

    // Next-state for mask, pending, edge history, clear counter and CP0 vector; a new edge beats a same-cycle clear.
    always_comb begin
        irq_d    = irq_in;
        rise     = irq_in & ~irq_q;
        clr      = '0;
        imr_d    = imr_q;
        icnt_d   = icnt_q;
        masked   = ipr_q & imr_q;
        hw_int_d = masked;

        if (we && reg_idx == IC_IMR) begin
            imr_d = wdata;
        end
        if (we && reg_idx == IC_IPR) begin
            clr = wdata;
        end

        ipr_d = (ipr_q & ~clr) | rise;

        if (|(clr & ipr_q & ~rise)) begin
            icnt_d = icnt_q + 32'd1;
        end
    end

    // Register read mux, selected by word index within the controller window.
    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            IC_IMR:  rdata = 32'(imr_q);
            IC_IPR:  rdata = 32'(ipr_q);
            IC_IVEC: rdata = lowest_set_index(masked);
            IC_ICNT: rdata = icnt_q;
            default: rdata = 32'd0;
        endcase
    end

    // State registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            imr_q    <= '0;
            ipr_q    <= '0;
            irq_q    <= '0;
            hw_int_q <= '0;
            icnt_q   <= 32'd0;
        end else begin
            imr_q    <= imr_d;
            ipr_q    <= ipr_d;
            irq_q    <= irq_d;
            hw_int_q <= hw_int_d;
            icnt_q   <= icnt_d;
        end
    end

    assign hw_int = hw_int_q;

endmodule

// File: rtl/dev_bridge.sv
// Bridge between the CPU data-memory port and the timers / interrupt
// controller. Decodes each access, steers write enables in the same cycle,
// and returns read data and error status one cycle after the request.
module dev_bridge
    import dev_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dev_bridge_if.slave      cpu,
    output logic [29:0]      dev_addr,
    output logic [31:0]      dev_wdata,
    output logic             t0_we,
    output logic             t1_we,
    input  logic [31:0]      t0_rdata,
    input  logic [31:0]      t1_rdata,
    input  logic [N_IRQ-1:0] irq_in,
    output logic [N_IRQ-1:0] hw_int
);

    sel_e        sel;
    logic [31:0] t0_off, t1_off, ic_off;
    logic        hit;
    logic        wr, rd;
    logic        ic_we;
    logic [31:0] ic_rdata;
    logic [31:0] sel_rdata;

    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;

    // Address decode; offsets wrap below each base, so one unsigned compare bounds the window.
    always_comb begin
        t0_off = cpu.addr - T0_BASE;
        t1_off = cpu.addr - T1_BASE;
        ic_off = cpu.addr - IC_BASE;
        sel    = SEL_NONE;
        if (cpu.addr[1:0] == 2'b00) begin
            if (t0_off < TIMER_WIN) begin
                sel = SEL_T0;
            end else if (t1_off < TIMER_WIN) begin
                sel = SEL_T1;
            end else if (ic_off < IC_WIN) begin
                sel = SEL_IC;
            end
        end
        hit = (sel != SEL_NONE);
    end

    // Write steering and read-data selection for the current request.
    always_comb begin
        wr    = cpu.req & cpu.we;
        rd    = cpu.req & ~cpu.we;
        t0_we = wr && (sel == SEL_T0);
        t1_we = wr && (sel == SEL_T1);
        ic_we = wr && (sel == SEL_IC);
        case (sel)
            SEL_T0:  sel_rdata = t0_rdata;
            SEL_T1:  sel_rdata = t1_rdata;
            SEL_IC:  sel_rdata = ic_rdata;
            default: sel_rdata = 32'd0;
        endcase
    end

    // Response pipeline next-state: data held between reads, faulting reads return zero.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd;
        err_d    = cpu.req & ~hit;
        if (rd) begin
            rdata_d = hit ? sel_rdata : 32'd0;
        end
    end

    // Response registers; reset drops any response still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign cpu.rdata  = rdata_q;
    assign cpu.rvalid = rvalid_q;
    assign cpu.err    = err_q;
    assign dev_addr   = cpu.addr[31:2];
    assign dev_wdata  = cpu.wdata;

    irq_ctrl u_irq_ctrl (
        .clk     (clk),
        .reset   (reset),
        .we      (ic_we),
        .reg_idx (cpu.addr[3:2]),
        .wdata   (cpu.wdata[N_IRQ-1:0]),
        .irq_in  (irq_in),
        .rdata   (ic_rdata),
        .hw_int  (hw_int)
    );

endmodule

// File: tb/tb_dev_bridge.sv
// Self-checking bench for dev_bridge: a table of single-cycle decode/read
// vectors applied back to back, then hand-written interrupt sequences.
module tb_dev_bridge;

    logic        clk;
    logic        reset;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic        t0_we;
    logic        t1_we;
    logic [31:0] t0_rdata;
    logic [31:0] t1_rdata;
    logic [5:0]  irq_in;
    logic [5:0]  hw_int;

    int test_count = 0;
    int fail_count = 0;

    dev_bridge_if bus ();

    dev_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (bus),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .t0_we     (t0_we),
        .t1_we     (t1_we),
        .t0_rdata  (t0_rdata),
        .t1_rdata  (t1_rdata),
        .irq_in    (irq_in),
        .hw_int    (hw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] t0_rd;
        logic [31:0] t1_rd;
        logic        exp_t0_we;
        logic        exp_t1_we;
        logic        exp_rvalid;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] t0_rd, input logic [31:0] t1_rd,
                                input logic e_t0, input logic e_t1, input logic e_rv,
                                input logic e_err, input logic [31:0] e_rdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.t0_rd = t0_rd; v.t1_rd = t1_rd;
        v.exp_t0_we = e_t0; v.exp_t1_we = e_t1; v.exp_rvalid = e_rv;
        v.exp_err = e_err; v.exp_rdata = e_rdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req   = req;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic doRead(input string name, input logic [31:0] addr, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b0, addr, 32'd0);
        step();
        checkOutput({name, " rvalid"}, 32'(bus.rvalid), 32'd1);
        checkOutput({name, " err"}, 32'(bus.err), 32'd0);
        checkOutput({name, " rdata"}, bus.rdata, expected);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        irq_in   = 6'd0;
        t0_rdata = 32'd0;
        t1_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);

        // Decode and read-path vectors; IC is untouched so IMR/IPR/ICNT are zero.
        vq.push_back(mk(0, 32'h7F00, 0, 32'hA5A5_0001, 0,            0, 0, 1, 0, 32'hA5A5_0001));
        vq.push_back(mk(0, 32'h7F08, 0, 32'h1234_5678, 0,            0, 0, 1, 0, 32'h1234_5678));
        vq.push_back(mk(0, 32'h7F0C, 0, 32'hFFFF_0000, 0,            0, 0, 1, 1, 32'd0));
        vq.push_back(mk(1, 32'h7F14, 32'd100, 0, 0,                  0, 1, 0, 0, 32'd0));
        vq.push_back(mk(0, 32'h7F14, 0, 0, 32'd100,                  0, 0, 1, 0, 32'd100));
        vq.push_back(mk(1, 32'h7F04, 32'hDEAD_BEEF, 0, 0,            1, 0, 0, 0, 32'd0));
        vq.push_back(mk(0, 32'h7F1C, 0, 0, 32'h7777_7777,            0, 0, 1, 1, 32'd0));
        vq.push_back(mk(0, 32'h7F30, 0, 0, 0,                        0, 0, 1, 1, 32'd0));
        vq.push_back(mk(0, 32'h7F02, 0, 32'h5555_5555, 0,            0, 0, 1, 1, 32'd0));
        vq.push_back(mk(1, 32'h7F02, 32'h1, 0, 0,                    0, 0, 0, 1, 32'd0));
        vq.push_back(mk(1, 32'h7F30, 32'h2, 0, 0,                    0, 0, 0, 1, 32'd0));
        vq.push_back(mk(0, 32'h7F28, 0, 0, 0,                        0, 0, 1, 0, 32'hFFFF_FFFF));
        vq.push_back(mk(0, 32'h7F2C, 0, 0, 0,                        0, 0, 1, 0, 32'd0));
        vq.push_back(mk(0, 32'h7F24, 0, 0, 0,                        0, 0, 1, 0, 32'd0));
        vq.push_back(mk(1, 32'h7F28, 32'h3, 0, 0,                    0, 0, 0, 0, 32'd0));
        vq.push_back(mk(0, 32'h7F10, 0, 0, 32'h0000_0055,            0, 0, 1, 0, 32'h0000_0055));
        vq.push_back(mk(0, 32'h0000_FF00, 0, 32'h9, 32'h9,           0, 0, 1, 1, 32'd0));
        vq.push_back(mk(1, 32'h7F18, 32'hCAFE_0000, 0, 0,            0, 1, 0, 0, 32'd0));

        // Reset state.
        step();
        step();
        checkOutput("reset rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("reset err", 32'(bus.err), 32'd0);
        checkOutput("reset rdata", bus.rdata, 32'd0);
        checkOutput("reset hw_int", 32'(hw_int), 32'd0);
        reset = 1'b0;
        doRead("post-reset IMR", 32'h7F20, 32'd0);
        checkOutput("post-reset hw_int", 32'(hw_int), 32'd0);

        // Table vectors, issued on consecutive cycles.
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(1'b1, vq[i].we, vq[i].addr, vq[i].wdata);
            t0_rdata = vq[i].t0_rd;
            t1_rdata = vq[i].t1_rd;
            #1;
            checkOutput($sformatf("v%0d t0_we", i), 32'(t0_we), 32'(vq[i].exp_t0_we));
            checkOutput($sformatf("v%0d t1_we", i), 32'(t1_we), 32'(vq[i].exp_t1_we));
            checkOutput($sformatf("v%0d dev_addr", i), 32'(dev_addr), {2'b00, vq[i].addr[31:2]});
            if (vq[i].we) begin
                checkOutput($sformatf("v%0d dev_wdata", i), dev_wdata, vq[i].wdata);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d rvalid", i), 32'(bus.rvalid), 32'(vq[i].exp_rvalid));
            checkOutput($sformatf("v%0d err", i), 32'(bus.err), 32'(vq[i].exp_err));
            if (!vq[i].we) begin
                checkOutput($sformatf("v%0d rdata", i), bus.rdata, vq[i].exp_rdata);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        t0_rdata = 32'd0;
        t1_rdata = 32'd0;
        step();
        checkOutput("idle rvalid", 32'(bus.rvalid), 32'd0);

        // Timer 1 edge: pending, masked vector, clear, no re-set while level stays high.
        doWrite(32'h7F20, 32'h0000_0003);
        irq_in[1] = 1'b1;
        step();
        step();
        step();
        checkOutput("t1 hw_int", 32'(hw_int), 32'h2);
        doRead("t1 IPR", 32'h7F24, 32'h2);
        doRead("t1 IVEC", 32'h7F28, 32'd1);
        doWrite(32'h7F24, 32'h2);
        step();
        checkOutput("t1 hw_int cleared", 32'(hw_int), 32'h0);
        doRead("t1 IPR cleared", 32'h7F24, 32'h0);
        doRead("t1 ICNT", 32'h7F2C, 32'd1);
        irq_in[1] = 1'b0;
        step();

        // Same-cycle rise and clear of bit 0: set wins, count unchanged.
        irq_in[0] = 1'b1;
        step();
        irq_in[0] = 1'b0;
        step();
        irq_in[0] = 1'b1;
        doWrite(32'h7F24, 32'h1);
        doRead("race IPR", 32'h7F24, 32'h1);
        doRead("race ICNT", 32'h7F2C, 32'd1);
        doWrite(32'h7F24, 32'h1);
        doRead("clear IPR", 32'h7F24, 32'h0);
        doRead("clear ICNT", 32'h7F2C, 32'd2);
        irq_in[0] = 1'b0;

        // External IRQ 4 pending while masked, then unmasked.
        doWrite(32'h7F20, 32'hFFFF_FF00);
        doRead("IMR zero", 32'h7F20, 32'h0);
        irq_in[4] = 1'b1;
        step();
        doRead("ext IPR", 32'h7F24, 32'h10);
        checkOutput("ext hw_int masked", 32'(hw_int), 32'h0);
        doRead("ext IVEC none", 32'h7F28, 32'hFFFF_FFFF);
        doWrite(32'h7F20, 32'hFFFF_FF10);
        checkOutput("ext hw_int lag", 32'(hw_int), 32'h0);
        step();
        checkOutput("ext hw_int", 32'(hw_int), 32'h10);
        doRead("IMR upper bits", 32'h7F20, 32'h10);
        doRead("ext IVEC", 32'h7F28, 32'd4);
        irq_in[4] = 1'b0;
        step();

        // Reset in the same cycle as a faulting read cancels the response.
        applyStimulus(1'b1, 1'b0, 32'h7F30, 32'd0);
        reset = 1'b1;
        step();
        checkOutput("reset-cancel rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("reset-cancel err", 32'(bus.err), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        step();
        checkOutput("after-reset rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("after-reset err", 32'(bus.err), 32'd0);
        checkOutput("after-reset hw_int", 32'(hw_int), 32'd0);
        doRead("after-reset IMR", 32'h7F20, 32'd0);
        doRead("after-reset ICNT", 32'h7F2C, 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
